// File: rtl/hpdcache_refill_fifo_pkg.sv
// Shared definitions for the HPDcache refill-response buffer.
// Holds the refill beat payload type, the beat width derived from the cache
// access geometry, the default buffer depth derived from the MSHR geometry,
// and a helper that sizes the buffer pointers.
// Optional feature macro used by the top level: HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN.
package hpdcache_refill_fifo_pkg;

    // Cache access geometry
    localparam int unsigned HPDCACHE_ACCESS_WORDS = 4;
    localparam int unsigned HPDCACHE_WORD_WIDTH   = 64;

    // MSHR geometry
    localparam int unsigned HPDCACHE_MSHR_SETS = 2;
    localparam int unsigned HPDCACHE_MSHR_WAYS = 2;

    // Refill beat width: one full access line per beat
    localparam int unsigned HPDCACHE_REFILL_BEAT_WIDTH = HPDCACHE_ACCESS_WORDS * HPDCACHE_WORD_WIDTH;

    // MSHR identifier width
    localparam int unsigned HPDCACHE_REFILL_ID_WIDTH = 4;

    // Depth that covers every outstanding MSHR plus slack for in-flight beats
    localparam int unsigned HPDCACHE_REFILL_FIFO_DEPTH = HPDCACHE_MSHR_SETS * HPDCACHE_MSHR_WAYS + 10;

    // Refill beat payload for the default geometry
    typedef struct packed {
        logic [HPDCACHE_REFILL_BEAT_WIDTH-1:0] data;
        logic [HPDCACHE_REFILL_ID_WIDTH-1:0]   id;
        logic                                  err;
        logic                                  last;
    } hpdcache_refill_beat_t;

    // Pointer width for a buffer of the given depth (at least one bit)
    function automatic int unsigned hpdcache_refill_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_refill_fifo_mem.sv
// Storage array of the refill buffer.
// DEPTH entries of WIDTH bits, one synchronous write port and one
// asynchronous read port. The array carries no reset: validity is tracked
// by the occupancy logic in the parent.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module hpdcache_refill_fifo_mem
    import hpdcache_refill_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = hpdcache_refill_ptr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read port
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hpdcache_refill_fifo.sv
// Refill-response buffer between the memory response channel and the
// HPDcache refill handler. Beats (data, MSHR id, error, last) leave in
// arrival order from a circular buffer of DEPTH entries.
// Optional macro HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN: when the buffer is
// empty, an incoming beat is presented on the read side in the same cycle
// and is not stored if it is consumed immediately.
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   w_valid_i / w_ready_o        producer handshake
//   w_data_i/w_id_i/w_err_i/w_last_i  incoming beat
//   r_valid_o / r_ready_i        refill handler handshake
//   r_data_o/r_id_o/r_err_o/r_last_o  head beat
//   count_o, full_o, empty_o     occupancy status
//   ovf_o                        sticky: push attempted while full
module hpdcache_refill_fifo
    import hpdcache_refill_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = HPDCACHE_REFILL_BEAT_WIDTH,
    parameter int unsigned ID_WIDTH   = HPDCACHE_REFILL_ID_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         w_valid_i,
    output logic                         w_ready_o,
    input  logic [DATA_WIDTH-1:0]        w_data_i,
    input  logic [ID_WIDTH-1:0]          w_id_i,
    input  logic                         w_err_i,
    input  logic                         w_last_i,

    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [DATA_WIDTH-1:0]        r_data_o,
    output logic [ID_WIDTH-1:0]          r_id_o,
    output logic                         r_err_o,
    output logic                         r_last_o,

    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         ovf_o
);

    localparam int unsigned PTR_W = hpdcache_refill_ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic                  err;
        logic                  last;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;

    logic  push_req;
    logic  pop_mem;
    logic  write_en;
    logic  bypass;
    beat_t w_beat;
    beat_t mem_beat;
    beat_t r_beat;
    logic  r_valid;

    assign w_beat = '{data: w_data_i, id: w_id_i, err: w_err_i, last: w_last_i};

    // Storage array
    hpdcache_refill_fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (BEAT_W),
        .ADDR_W (PTR_W)
    ) i_mem (
        .clk_i   (clk_i),
        .we_i    (write_en),
        .waddr_i (wptr_q),
        .wdata_i (w_beat),
        .raddr_i (rptr_q),
        .rdata_o (mem_beat)
    );

    // Read-side selection: stored head, or the incoming beat when bypassing
    always_comb begin
        r_valid = !empty_q;
        r_beat  = mem_beat;
        bypass  = 1'b0;
`ifdef HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN
        if (empty_q && w_valid_i) begin
            r_valid = 1'b1;
            r_beat  = w_beat;
            bypass  = r_ready_i;
        end
`endif
    end

    // Handshakes; a bypassed beat is consumed without touching the array
    assign push_req = w_valid_i && !full_q;
    assign pop_mem  = !empty_q && r_ready_i;
    assign write_en = push_req && !bypass;

    // Next-state for pointers, occupancy and flags
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (write_en) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop_mem) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end

        if (write_en && !pop_mem) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_mem && !write_en) begin
            count_d = count_q - CNT_W'(1);
        end

        if (w_valid_i && full_q) begin
            ovf_d = 1'b1;
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_ready_o = !full_q;
    assign r_valid_o = r_valid;
    assign r_data_o  = r_beat.data;
    assign r_id_o    = r_beat.id;
    assign r_err_o   = r_beat.err;
    assign r_last_o  = r_beat.last;
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_hpdcache_refill_fifo.sv
// Self-checking bench for hpdcache_refill_fifo: a DEPTH=2 instance for
// directed cases and a DEPTH=14 instance for a scoreboarded random stream.
module tb_hpdcache_refill_fifo;
    import hpdcache_refill_fifo_pkg::*;

    localparam int unsigned DW = HPDCACHE_REFILL_BEAT_WIDTH;
    localparam int unsigned IW = HPDCACHE_REFILL_ID_WIDTH;

    logic clk;
    logic rst_n;

    // DEPTH=2 instance signals
    logic          w2_valid, w2_ready, w2_err, w2_last;
    logic [DW-1:0] w2_data;
    logic [IW-1:0] w2_id;
    logic          r2_valid, r2_ready, r2_err, r2_last;
    logic [DW-1:0] r2_data;
    logic [IW-1:0] r2_id;
    logic [1:0]    c2_count;
    logic          c2_full, c2_empty, c2_ovf;

    // DEPTH=14 instance signals
    logic          w14_valid, w14_ready, w14_err, w14_last;
    logic [DW-1:0] w14_data;
    logic [IW-1:0] w14_id;
    logic          r14_valid, r14_ready, r14_err, r14_last;
    logic [DW-1:0] r14_data;
    logic [IW-1:0] r14_id;
    logic [3:0]    c14_count;
    logic          c14_full, c14_empty, c14_ovf;

    int errors = 0;
    int checks = 0;

    hpdcache_refill_beat_t sb_q[$];

    hpdcache_refill_fifo #(.DEPTH(2), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .w_valid_i(w2_valid), .w_ready_o(w2_ready), .w_data_i(w2_data),
        .w_id_i(w2_id), .w_err_i(w2_err), .w_last_i(w2_last),
        .r_valid_o(r2_valid), .r_ready_i(r2_ready), .r_data_o(r2_data),
        .r_id_o(r2_id), .r_err_o(r2_err), .r_last_o(r2_last),
        .count_o(c2_count), .full_o(c2_full), .empty_o(c2_empty), .ovf_o(c2_ovf)
    );

    hpdcache_refill_fifo #(.DEPTH(14), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut14 (
        .clk_i(clk), .rst_ni(rst_n),
        .w_valid_i(w14_valid), .w_ready_o(w14_ready), .w_data_i(w14_data),
        .w_id_i(w14_id), .w_err_i(w14_err), .w_last_i(w14_last),
        .r_valid_o(r14_valid), .r_ready_i(r14_ready), .r_data_o(r14_data),
        .r_id_o(r14_id), .r_err_o(r14_err), .r_last_o(r14_last),
        .count_o(c14_count), .full_o(c14_full), .empty_o(c14_empty), .ovf_o(c14_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state14(input string tag);
        check({tag, "_count14"}, 256'(c14_count), 256'(0));
        check({tag, "_empty14"}, 256'(c14_empty), 256'(1));
        check({tag, "_full14"},  256'(c14_full),  256'(0));
        check({tag, "_wrdy14"},  256'(w14_ready), 256'(1));
        check({tag, "_rvld14"},  256'(r14_valid), 256'(0));
        check({tag, "_ovf14"},   256'(c14_ovf),   256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hpdcache_refill_beat_t b;
        hpdcache_refill_beat_t e;
        logic [DW-1:0] a5;
        int sent;
        int rcvd;
        int cycles;

        rst_n = 1'b0;
        w2_valid = 0; w2_data = '0; w2_id = '0; w2_err = 0; w2_last = 0; r2_ready = 0;
        w14_valid = 0; w14_data = '0; w14_id = '0; w14_err = 0; w14_last = 0; r14_ready = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Reset then idle
        check_reset_state14("rst");
        for (int i = 0; i < 10; i++) begin
            check("idle_empty2", 256'(c2_empty), 256'(1));
            check("idle_wrdy2",  256'(w2_ready), 256'(1));
            check("idle_rvld2",  256'(r2_valid), 256'(0));
            check("idle_count2", 256'(c2_count), 256'(0));
            tick();
        end
        check("idle_ovf2", 256'(c2_ovf), 256'(0));

        // Fill DEPTH=2 with ids 1,2,3 while the handler stalls
        w2_valid = 1; w2_id = 4'd1; #1;
        check("fill1_wrdy", 256'(w2_ready), 256'(1));
        tick();
        w2_id = 4'd2; #1;
        check("fill2_wrdy", 256'(w2_ready), 256'(1));
        check("fill2_count", 256'(c2_count), 256'(1));
        tick();
        w2_id = 4'd3; #1;
        check("fill3_wrdy", 256'(w2_ready), 256'(0));
        check("fill3_full", 256'(c2_full), 256'(1));
        check("fill3_count", 256'(c2_count), 256'(2));
        tick();
        w2_valid = 0; #1;
        check("fill3_ovf", 256'(c2_ovf), 256'(1));
        check("fill3_count_after", 256'(c2_count), 256'(2));
        r2_ready = 1; #1;
        check("drain1_rvld", 256'(r2_valid), 256'(1));
        check("drain1_id", 256'(r2_id), 256'(1));
        tick();
        check("drain2_rvld", 256'(r2_valid), 256'(1));
        check("drain2_id", 256'(r2_id), 256'(2));
        tick();
        r2_ready = 0; #1;
        check("drain_empty", 256'(c2_empty), 256'(1));
        check("drain_count", 256'(c2_count), 256'(0));
        check("drain_rvld", 256'(r2_valid), 256'(0));
        check("ovf_sticky", 256'(c2_ovf), 256'(1));

        // Full with simultaneous push and pop: pop wins, push refused
        w2_valid = 1; w2_id = 4'd4; tick();
        w2_id = 4'd5; tick();
        w2_id = 4'd6; r2_ready = 1; #1;
        check("fullpp_wrdy", 256'(w2_ready), 256'(0));
        check("fullpp_id", 256'(r2_id), 256'(4));
        tick();
        r2_ready = 0; #1;
        check("fullpp_count1", 256'(c2_count), 256'(1));
        check("fullpp_wrdy_next", 256'(w2_ready), 256'(1));
        tick();
        w2_valid = 0; #1;
        check("fullpp_count2", 256'(c2_count), 256'(2));
        r2_ready = 1; #1;
        check("fullpp_pop5", 256'(r2_id), 256'(5));
        tick();
        check("fullpp_pop6", 256'(r2_id), 256'(6));
        tick();
        r2_ready = 0; #1;
        check("fullpp_empty", 256'(c2_empty), 256'(1));

        // Empty buffer, valid and ready together
        a5 = {32{8'hA5}};
        w2_data = a5; w2_id = 4'd9; w2_valid = 1; r2_ready = 1; #1;
`ifdef HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN
        check("ft_rvld", 256'(r2_valid), 256'(1));
        check("ft_data", 256'(r2_data), 256'(a5));
        check("ft_id", 256'(r2_id), 256'(9));
        tick();
        w2_valid = 0; r2_ready = 0; #1;
        check("ft_count", 256'(c2_count), 256'(0));
        check("ft_empty", 256'(c2_empty), 256'(1));
`else
        check("noft_rvld0", 256'(r2_valid), 256'(0));
        tick();
        w2_valid = 0; r2_ready = 0; #1;
        check("noft_rvld1", 256'(r2_valid), 256'(1));
        check("noft_count", 256'(c2_count), 256'(1));
        check("noft_data", 256'(r2_data), 256'(a5));
        r2_ready = 1; tick();
        r2_ready = 0; #1;
        check("noft_empty", 256'(c2_empty), 256'(1));
`endif

        // Random stream through DEPTH=14 with stalls on both sides
        sent = 0; rcvd = 0; cycles = 0;
        while (rcvd < 1000 && cycles < 20000) begin
            w14_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) w14_data[k*32 +: 32] = $urandom();
            w14_id   = IW'(sent);
            w14_err  = 1'($urandom_range(0, 1));
            w14_last = (sent % 4) == 3;
            r14_ready = ($urandom_range(0, 1) != 0);
            #1;
            if (w14_valid && w14_ready) begin
                b.data = w14_data; b.id = w14_id; b.err = w14_err; b.last = w14_last;
                sb_q.push_back(b);
                sent++;
            end
            if (r14_valid && r14_ready) begin
                if (sb_q.size() == 0) begin
                    check("rnd_spurious_pop", 256'(1), 256'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("rnd_data", 256'(r14_data), 256'(e.data));
                    check("rnd_meta", 256'({r14_id, r14_err, r14_last}), 256'({e.id, e.err, e.last}));
                end
                rcvd++;
            end
            tick();
            check("rnd_count", 256'(c14_count), 256'(sb_q.size()));
            cycles++;
        end
        check("rnd_received", 256'(rcvd), 256'(1000));
        w14_valid = 0; r14_ready = 0;

        // Asynchronous reset with three beats stored
        w14_valid = 1; w14_id = 4'd7; tick();
        w14_id = 4'd8; tick();
        w14_id = 4'd9; tick();
        w14_valid = 0; #1;
        check("pre_rst_count", 256'(c14_count), 256'(3));
        #1 rst_n = 1'b0;
        #1;
        check_reset_state14("mid_rst");
        check("mid_rst_ovf2", 256'(c2_ovf), 256'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_rvld", 256'(r14_valid), 256'(0));
            check("post_rst_count", 256'(c14_count), 256'(0));
        end
        w14_valid = 1; w14_id = 4'd10; tick();
        w14_valid = 0; #1;
        check("post_rst_rvld_new", 256'(r14_valid), 256'(1));
        check("post_rst_id_new", 256'(r14_id), 256'(10));
        check("post_rst_count_new", 256'(c14_count), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpdcache_refill_fifo.md
# hpdcache_refill_fifo

Buffers refill-response beats (data, MSHR id, error, last) arriving from the memory interface before the HPDcache refill handler writes them into the data RAM and forwards words to the core. The buffer sits directly between the memory response channel and the refill handler. It is sized from the cache parameters: depth is the refill FIFO depth, and beat width is access-words × word width. An optional same-cycle feedthrough path removes one cycle of refill latency when the buffer is empty.

## Interface
Parameters:
- DEPTH, default 2: number of entries. Must be ≥1; non-power-of-2 values are legal, e.g. 14.
- DATA_WIDTH, default 256: beat width in bits (ACCESS_WORDS × WORD_WIDTH).
- ID_WIDTH, default 4: MSHR id width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock domain, asynchronous, active-low
- w_valid_i  in  1  producer beat valid
- w_ready_o  out  1  buffer can accept a beat
- w_data_i  in  DATA_WIDTH  beat data
- w_id_i  in  ID_WIDTH  MSHR id
- w_err_i  in  1  bus error on beat
- w_last_i  in  1  final beat of refill
- r_valid_o  out  1  beat available to the refill handler
- r_ready_i  in  1  refill handler consumes
- r_data_o / r_id_o / r_err_o / r_last_o  out  DATA_WIDTH / ID_WIDTH / 1 / 1  head beat
- count_o  out  $clog2(DEPTH+1)  occupancy
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- ovf_o  out  1  sticky flag: a push was attempted while full and not ready

## Operation
- Push: a beat is pushed when w_valid_i && w_ready_o. w_ready_o = !full_o. It depends only on registered state, with no combinational path from r_ready_i.
- Pop: a beat is popped when r_valid_o && r_ready_i. Without feedthrough, r_valid_o = !empty_o.
- Storage: circular buffer with write pointer and read pointer. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- Ordering: beats leave in arrival order. Payload fields travel together and are never reordered.
- Occupancy:
  - Push only: count +1.
  - Pop only: count -1.
  - Push and pop in the same cycle: count unchanged, and both pointers advance.
- Full with pop: w_ready_o stays 0 in that cycle, so the producer is refused. Space is freed for the next cycle.
- Overflow: w_valid_i=1 while full sets ovf_o. This is protocol-legal backpressure, but the refill path is sized never to hit it, so it is flagged for debug. ovf_o clears only on reset.
- Unused outputs: r_*_o payload outputs are undefined while r_valid_o=0. A bench must not check them then.

## Timing
- Reset values: count_o=0, empty_o=1, full_o=0, w_ready_o=1, r_valid_o=0, ovf_o=0. Both pointers are 0.
- Reset asserted mid-operation discards all stored beats asynchronously.
- Latency without feedthrough: a beat pushed in cycle N is visible on r_*_o in cycle N+1.
- Pop timing: when r_ready_i=1, the head advances at the clock edge.

## Configuration
- Macro HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN.
- Defined, bypass condition: empty_o && w_valid_i holds in the cycle.
  - r_valid_o=1 and r_*_o = w_*_i combinationally.
  - If r_ready_i=1 as well, the beat is consumed with no write, and count stays 0.
  - If r_ready_i=0, the beat is written normally.
- Defined, non-empty buffer: behaviour is identical to the non-feedthrough case.
- Undefined: no combinational path from w_* to r_*. Minimum latency is 1 cycle.

## Structure
- Shared package holds:
  - typedef hpdcache_refill_beat_t (data, id, err, last);
  - the refill beat width constant, derived from the access-words and word-width parameters;
  - the default depth, derived from MSHR sets × ways + 10.
- One sub-module, hpdcache_refill_fifo_mem:
  - DEPTH × beat register array;
  - one write port and one asynchronous read port;
  - no reset on the data array.
- Top level holds the pointers, counter, flags and bypass mux.

## Test plan
- Reset then idle: after rst_ni deasserts, empty_o=1, w_ready_o=1, r_valid_o=0, count_o=0, with no change over 10 cycles.
- DEPTH=2, r_ready_i=0, push ids 1,2,3 on consecutive cycles:
  - ids 1 and 2 are accepted;
  - full_o=1 and w_ready_o=0 on the 3rd cycle;
  - ovf_o=1;
  - after enabling r_ready_i, pops return 1 then 2.
- DEPTH=14, continuous push/pop with random stalls for 1000 beats: output sequence equals input sequence, which checks pointer wrap at 13→0.
- Full, with simultaneous w_valid_i and r_ready_i: pop occurs, push is refused, and count goes 2→1. In the next cycle the push is accepted and count returns to 2.
- Feedthrough defined, empty, w_valid_i=r_ready_i=1 with data 0xA5…: r_data_o=0xA5… in the same cycle and count_o stays 0. Undefined: r_valid_o rises one cycle later with count_o=1.
- rst_ni asserted while count_o=3: all outputs return to reset values immediately, and no stale beat appears after release.
